// File: rtl/inst_fetch_cache.sv
// Instruction-fetch responder: direct-mapped, word-granular I-cache that refills
// missing words one byte at a time through the shared memory arbiter.
module inst_fetch_cache #(
    parameter int IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _need_inst,
    input  logic [31:0] _pc,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_out,
    output logic        _mem_rd_req,
    output logic [31:0] _mem_addr,
    input  logic        _mem_grant,
    input  logic [7:0]  _mem_byte_in
);
    localparam int LINES = 2 ** IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:2]       req_pc_q, req_pc_d;
    logic [2:0]        iss_q, iss_d;
    logic [2:0]        rcv_q, rcv_d;
    logic              pend_q, pend_d;
    logic [23:0]       bytes_q, bytes_d;
    logic [31:0]       inst_q, inst_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [31:0]       data_q [LINES];

    logic [IDX_W-1:0]  pc_idx, req_idx;
    logic [TAG_W-1:0]  pc_tag, req_tag;
    logic              hit;
    logic              issuing;
    logic              line_we;
    logic [31:0]       line_word;
    logic              unused_pc_bits;

    assign pc_idx         = _pc[IDX_W+1:2];
    assign pc_tag         = _pc[31:IDX_W+2];
    assign req_idx        = req_pc_q[IDX_W+1:2];
    assign req_tag        = req_pc_q[31:IDX_W+2];
    assign hit            = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign issuing        = (state_q == FILL) && (iss_q < 3'd4);
    assign line_word      = {_mem_byte_in, bytes_q};
    assign unused_pc_bits = ^_pc[1:0];

    assign _inst_ready_out = (state_q == RESP);
    assign _inst_out       = inst_q;
    assign _mem_rd_req     = issuing;
    // Byte offset comes straight from the issue counter, so no carry into the word address.
    assign _mem_addr       = issuing ? {req_pc_q, iss_q[1:0]} : 32'd0;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        iss_d    = iss_q;
        rcv_d    = rcv_q;
        pend_d   = pend_q;
        bytes_d  = bytes_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        line_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (_need_inst) begin
                    req_pc_d = _pc[31:2];
                    iss_d    = 3'd0;
                    rcv_d    = 3'd0;
                    pend_d   = 1'b0;
                    if (hit) begin
                        inst_d  = data_q[pc_idx];
                        state_d = RESP;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                pend_d = issuing && _mem_grant;
                if (issuing && _mem_grant) begin
                    iss_d = iss_q + 3'd1;
                end
                // A byte granted last cycle is always captured, even while issuing is stalled.
                if (pend_q) begin
                    rcv_d = rcv_q + 3'd1;
                    case (rcv_q[1:0])
                        2'd0: bytes_d[7:0]   = _mem_byte_in;
                        2'd1: bytes_d[15:8]  = _mem_byte_in;
                        2'd2: bytes_d[23:16] = _mem_byte_in;
                        default: begin
                            line_we = 1'b1;
                            inst_d  = line_word;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flush still lets a just-completed line into the cache, but suppresses the response.
        if (_clear) begin
            state_d  = IDLE;
            req_pc_d = req_pc_q;
            iss_d    = 3'd0;
            rcv_d    = 3'd0;
            pend_d   = 1'b0;
            inst_d   = inst_q;
        end

        if (line_we) begin
            valid_d[req_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            iss_q    <= 3'd0;
            rcv_q    <= 3'd0;
            pend_q   <= 1'b0;
            bytes_q  <= '0;
            inst_q   <= 32'd0;
            valid_q  <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            iss_q    <= iss_d;
            rcv_q    <= rcv_d;
            pend_q   <= pend_d;
            bytes_q  <= bytes_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && line_we) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= line_word;
        end
    end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Self-checking bench for inst_fetch_cache: directed scenarios plus randomized fetches
// checked against a behavioural RAM/cache/latency model.
module tb_inst_fetch_cache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        need_inst;
    logic [31:0] pc;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_byte;

    int checks;
    int errors;

    bit          m_valid [16];
    logic [25:0] m_tag [16];

    int          obs_lat;
    int          exp_lat;
    logic [31:0] obs_data;
    logic        obs_ready_after;
    bit          obs_req_any;
    bit          exp_hit;
    logic [31:0] obs_addrs [$];

    inst_fetch_cache #(.IDX_W(4)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        ._clear         (clear),
        ._need_inst     (need_inst),
        ._pc            (pc),
        ._inst_ready_out(inst_ready),
        ._inst_out      (inst_out),
        ._mem_rd_req    (mem_rd_req),
        ._mem_addr      (mem_addr),
        ._mem_grant     (mem_grant),
        ._mem_byte_in   (mem_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002, 32'h1003: return 8'h00;
            default: return a[7:0] ^ {a[10:8], a[15:11]} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {ram_byte(w + 3), ram_byte(w + 2), ram_byte(w + 1), ram_byte(w)};
    endfunction

    // RAM behind the arbiter: one byte per granted address, garbage otherwise, frozen with rdy.
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_rd_req && mem_grant) mem_byte <= ram_byte(mem_addr);
            else                         mem_byte <= 8'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; need_inst = 1'b0; mem_grant = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Drives one fetch and records what the DUT did; expected latency comes from the model:
    // a hit answers in cycle 1, a miss answers two active cycles after its 4th granted issue.
    task automatic run_fetch(input logic [31:0] fpc, input int gap_start, input int gap_len,
                             input int stall_start, input int stall_len, input bit rnd_grant);
        int idx, act, m_iss, a4;
        bit stalled;
        idx     = int'(fpc[5:2]);
        exp_hit = m_valid[idx] && (m_tag[idx] == fpc[31:6]);
        exp_lat = exp_hit ? 1 : -1;
        obs_lat = -1;
        obs_data = 32'd0;
        obs_req_any = 1'b0;
        obs_addrs.delete();
        act = 0; m_iss = 0; a4 = -1;
        @(negedge clk);
        need_inst = 1'b1; pc = fpc; mem_grant = 1'b0; rdy = 1'b1; clear = 1'b0;
        @(posedge clk);
        #1 need_inst = 1'b0; pc = $urandom;
        for (int k = 1; k <= 150 && obs_lat < 0; k++) begin
            @(negedge clk);
            stalled   = !exp_hit && (k >= stall_start) && (k < stall_start + stall_len);
            rdy       = !stalled;
            mem_grant = rnd_grant ? ($urandom_range(0, 3) != 0) : !((k >= gap_start) && (k < gap_start + gap_len));
            if (mem_rd_req) obs_req_any = 1'b1;
            if (inst_ready) begin
                obs_lat  = k;
                obs_data = inst_out;
            end
            if (mem_rd_req && mem_grant && rdy) obs_addrs.push_back(mem_addr);
            if (!exp_hit && rdy) begin
                act++;
                if (m_iss < 4 && mem_grant) begin
                    m_iss++;
                    if (m_iss == 4) a4 = act;
                end
                if (a4 > 0 && act == a4 + 1) exp_lat = k + 1;
            end
        end
        rdy = 1'b1;
        mem_grant = 1'b0;
        @(negedge clk);
        obs_ready_after = inst_ready;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = fpc[31:6];
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; need_inst = 1'b0; pc = 32'd0; mem_grant = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (inst_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", inst_ready); end
        checks++; if (inst_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", inst_out); end
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_rd_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_req !== 1'b0 || inst_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: req %b ready %b expected 0 0", mem_rd_req, inst_ready); end
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h1000, 0, 0, 0, 0, 1'b0);
        checks++; if (obs_lat !== 6) begin errors++; $display("[TB] FAIL cold_miss_latency: got %0d expected 6", obs_lat); end
        checks++; if (obs_data !== 32'h00000513) begin errors++; $display("[TB] FAIL cold_miss_data: got %h expected 00000513", obs_data); end
        checks++; if (obs_addrs.size() !== 4) begin errors++; $display("[TB] FAIL cold_miss_addr_count: got %0d expected 4", obs_addrs.size()); end
        for (int i = 0; i < obs_addrs.size() && i < 4; i++) begin
            checks++; if (obs_addrs[i] !== 32'h1000 + i) begin errors++; $display("[TB] FAIL cold_miss_addr%0d: got %h expected %h", i, obs_addrs[i], 32'h1000 + i); end
        end
        checks++; if (obs_ready_after !== 1'b0) begin errors++; $display("[TB] FAIL cold_miss_pulse_width: got %b expected 0", obs_ready_after); end
    endtask

    task automatic test_hit();
        run_fetch(32'h1000, 0, 0, 0, 0, 1'b1);
        checks++; if (obs_lat !== 1) begin errors++; $display("[TB] FAIL hit_latency: got %0d expected 1", obs_lat); end
        checks++; if (obs_data !== 32'h00000513) begin errors++; $display("[TB] FAIL hit_data: got %h expected 00000513", obs_data); end
        checks++; if (obs_req_any !== 1'b0) begin errors++; $display("[TB] FAIL hit_mem_req: got %b expected 0", obs_req_any); end
        checks++; if (obs_ready_after !== 1'b0) begin errors++; $display("[TB] FAIL hit_pulse_width: got %b expected 0", obs_ready_after); end
    endtask

    task automatic test_conflict();
        logic [31:0] seq [2];
        seq[0] = 32'h1040;
        seq[1] = 32'h1000;
        for (int s = 0; s < 2; s++) begin
            run_fetch(seq[s], 0, 0, 0, 0, 1'b0);
            checks++; if (obs_lat !== 6) begin errors++; $display("[TB] FAIL conflict_latency_%h: got %0d expected 6", seq[s], obs_lat); end
            checks++; if (obs_data !== ram_word(seq[s])) begin errors++; $display("[TB] FAIL conflict_data_%h: got %h expected %h", seq[s], obs_data, ram_word(seq[s])); end
        end
    endtask

    task automatic test_reset_override();
        @(negedge clk);
        need_inst = 1'b1; pc = 32'h2000; mem_grant = 1'b1;
        @(posedge clk);
        #1 need_inst = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_rdy_req: got %b expected 0", mem_rd_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL rst_over_rdy_addr: got %h expected 0", mem_addr); end
        checks++; if (inst_out !== 32'd0) begin errors++; $display("[TB] FAIL rst_over_rdy_inst: got %h expected 0", inst_out); end
        rdy = 1'b1; mem_grant = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (inst_ready !== 1'b0 || mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_rdy_idle: ready %b req %b expected 0 0", inst_ready, mem_rd_req); end
        run_fetch(32'h1000, 0, 0, 0, 0, 1'b0);
        checks++; if (obs_lat !== 6) begin errors++; $display("[TB] FAIL reset_invalidates_latency: got %0d expected 6", obs_lat); end
    endtask

    task automatic test_grant_gap();
        do_reset();
        run_fetch(32'h1000, 3, 3, 0, 0, 1'b0);
        checks++; if (obs_lat !== 9) begin errors++; $display("[TB] FAIL grant_gap_latency: got %0d expected 9", obs_lat); end
        checks++; if (obs_data !== 32'h00000513) begin errors++; $display("[TB] FAIL grant_gap_data: got %h expected 00000513", obs_data); end
        checks++; if (obs_addrs.size() !== 4) begin errors++; $display("[TB] FAIL grant_gap_addr_count: got %0d expected 4", obs_addrs.size()); end
        for (int i = 0; i < obs_addrs.size() && i < 4; i++) begin
            checks++; if (obs_addrs[i] !== 32'h1000 + i) begin errors++; $display("[TB] FAIL grant_gap_addr%0d: got %h expected %h", i, obs_addrs[i], 32'h1000 + i); end
        end
    endtask

    task automatic test_flush();
        int pulses;
        do_reset();
        @(negedge clk);
        need_inst = 1'b1; pc = 32'h1000; mem_grant = 1'b1;
        @(posedge clk);
        #1 need_inst = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        clear = 1'b1; need_inst = 1'b1; pc = 32'h1040;
        @(posedge clk);
        #1 clear = 1'b0; need_inst = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_req: got %b expected 0", mem_rd_req); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("[TB] FAIL flush_addr: got %h expected 0", mem_addr); end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (inst_ready) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL flush_no_ready: got %0d pulses expected 0", pulses); end
        mem_grant = 1'b0;
        run_fetch(32'h1000, 0, 0, 0, 0, 1'b0);
        checks++; if (obs_lat !== 6) begin errors++; $display("[TB] FAIL flush_refetch_latency: got %0d expected 6", obs_lat); end
        checks++; if (obs_data !== 32'h00000513) begin errors++; $display("[TB] FAIL flush_refetch_data: got %h expected 00000513", obs_data); end
    endtask

    task automatic test_flush_last_byte();
        do_reset();
        @(negedge clk);
        need_inst = 1'b1; pc = 32'h1040; mem_grant = 1'b1;
        @(posedge clk);
        #1 need_inst = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; mem_grant = 1'b0;
        @(negedge clk);
        checks++; if (inst_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_last_ready: got %b expected 0", inst_ready); end
        m_valid[0]  = 1'b1;
        m_tag[0]    = 26'(32'h1040 >> 6);
        run_fetch(32'h1040, 0, 0, 0, 0, 1'b0);
        checks++; if (obs_lat !== 1) begin errors++; $display("[TB] FAIL flush_last_line_written: got latency %0d expected 1", obs_lat); end
        checks++; if (obs_data !== ram_word(32'h1040)) begin errors++; $display("[TB] FAIL flush_last_data: got %h expected %h", obs_data, ram_word(32'h1040)); end
    endtask

    task automatic test_clear_idle();
        @(negedge clk);
        clear = 1'b1; need_inst = 1'b1; pc = 32'h2000; mem_grant = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; need_inst = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_req !== 1'b0 || inst_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_ignores_need: req %b ready %b expected 0 0", mem_rd_req, inst_ready); end
        mem_grant = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        run_fetch(32'h1000, 0, 0, 3, 4, 1'b0);
        checks++; if (obs_lat !== 10) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 10", obs_lat); end
        checks++; if (obs_data !== 32'h00000513) begin errors++; $display("[TB] FAIL stall_data: got %h expected 00000513", obs_data); end
        checks++; if (obs_addrs.size() !== 4) begin errors++; $display("[TB] FAIL stall_addr_count: got %0d expected 4", obs_addrs.size()); end
    endtask

    task automatic test_random();
        logic [31:0] p;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: p = 32'h1000;
                1: p = 32'h1040;
                2: p = 32'h2000;
                3: p = 32'h1004;
                4: p = 32'h3ffc;
                default: p = $urandom & 32'h0000_3ffc;
            endcase
            p[1:0] = 2'($urandom_range(0, 3));
            run_fetch(p, 0, 0, $urandom_range(1, 3), $urandom_range(0, 3), 1'b1);
            checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL rand%0d_latency pc=%h: got %0d expected %0d", n, p, obs_lat, exp_lat); end
            checks++; if (obs_data !== ram_word(p)) begin errors++; $display("[TB] FAIL rand%0d_data pc=%h: got %h expected %h", n, p, obs_data, ram_word(p)); end
            if (exp_hit) begin
                checks++; if (obs_req_any !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_hit_req: got %b expected 0", n, obs_req_any); end
            end else begin
                checks++; if (obs_addrs.size() !== 4) begin errors++; $display("[TB] FAIL rand%0d_addr_count: got %0d expected 4", n, obs_addrs.size()); end
                for (int i = 0; i < obs_addrs.size() && i < 4; i++) begin
                    checks++; if (obs_addrs[i] !== {p[31:2], 2'b00} + i) begin errors++; $display("[TB] FAIL rand%0d_addr%0d: got %h expected %h", n, i, obs_addrs[i], {p[31:2], 2'b00} + i); end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_reset_override();
        test_grant_gap();
        test_flush();
        test_flush_last_byte();
        test_clear_idle();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
